// File: rtl/adder_tree_sched_if.sv
// Stream bundle for adder_tree_sched.
//   in_*  : window beat stream (producer -> block), valid/ready.
//   out_* : requantized pixel stream (block -> consumer), valid/ready.
// Modports: master = producer/consumer side (testbench), slave = the block.
interface adder_tree_sched_if #(
  parameter int unsigned NINPUTS = 27,
  parameter int unsigned IWIDTH  = 8,
  parameter int unsigned AWIDTH  = 24,
  parameter int unsigned OWIDTH  = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NINPUTS*IWIDTH-1:0]     in_d;
  logic signed [AWIDTH-1:0]      in_bias;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OWIDTH-1:0]      out_q;
  logic                          out_sat;

  modport master (
    output in_valid, in_d, in_bias, out_ready,
    input  in_ready, out_valid, out_q, out_sat
  );

  modport slave (
    input  in_valid, in_d, in_bias, out_ready,
    output in_ready, out_valid, out_q, out_sat
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Sequencer for an external 27-input combinational adder tree.
// Accepts NCH window beats per output pixel, presents each beat to the tree from a register
// stage, accumulates tree sums on top of a per-pixel bias, then rounds, shifts and saturates
// the total and offers it on an output valid/ready stream.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of adder_tree_sched_if (in_* beat stream, out_* result stream)
//   tree_d   : registered tree inputs (NINPUTS x IWIDTH, element i at bits [i*IWIDTH +: IWIDTH])
//   tree_q   : combinational tree sum of tree_d
//   busy     : high whenever the FSM is not idle
module adder_tree_sched #(
  parameter int unsigned NINPUTS = 27,
  parameter int unsigned IWIDTH  = 8,
  parameter int unsigned TWIDTH  = 18,
  parameter int unsigned NCH     = 16,
  parameter int unsigned AWIDTH  = 24,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned OWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  adder_tree_sched_if.slave         bus,
  output logic [NINPUTS*IWIDTH-1:0] tree_d,
  input  logic signed [TWIDTH-1:0]  tree_q,
  output logic                      busy
);

  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;
  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned RW   = AWIDTH + 1;

  localparam logic signed [RW-1:0] Half = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] OMax = RW'((1 << (OWIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OMin = RW'(-(1 << (OWIDTH - 1)));

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  state_e                    state_q;
  logic [CntW-1:0]           ch_cnt_q;
  logic signed [AWIDTH-1:0]  acc_q;
  logic                      tv_q;   // tree_d holds a beat not yet folded into acc_q
  logic [NINPUTS*IWIDTH-1:0] tree_d_q;
  logic signed [OWIDTH-1:0]  out_q_q;
  logic                      out_sat_q;
  logic                      out_valid_q;

  logic                      accept;
  logic                      last_beat;
  logic signed [AWIDTH-1:0]  tree_ext;
  logic signed [AWIDTH-1:0]  sum;
  logic signed [RW-1:0]      sum_w;
  logic signed [RW-1:0]      rnd;
  logic signed [RW-1:0]      shifted;
  logic                      sat_hi;
  logic                      sat_lo;
  logic signed [OWIDTH-1:0]  clip;

  assign bus.in_ready  = ((state_q == StIdle) || (state_q == StAccum)) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_beat     = (ch_cnt_q == CntW'(NCH - 1));
  assign tree_ext      = {{(AWIDTH - TWIDTH){tree_q[TWIDTH-1]}}, tree_q};

  assign tree_d        = tree_d_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != StIdle);

  // Requantize the final sum: the last beat's tree output is still combinational in DRAIN.
  always_comb begin
    sum     = acc_q + tree_ext;
    sum_w   = {sum[AWIDTH-1], sum};
    rnd     = sum_w + Half;
    shifted = rnd >>> SHIFT;
    sat_hi  = (shifted > OMax);
    sat_lo  = (shifted < OMin);
    if (sat_hi) begin
      clip = OMax[OWIDTH-1:0];
    end else if (sat_lo) begin
      clip = OMin[OWIDTH-1:0];
    end else begin
      clip = shifted[OWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_cnt_q    <= '0;
      acc_q       <= '0;
      tv_q        <= 1'b0;
      tree_d_q    <= '0;
      out_q_q     <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        tree_d_q <= bus.in_d;
        tv_q     <= 1'b1;
        ch_cnt_q <= last_beat ? '0 : ch_cnt_q + CntW'(1);
      end else begin
        tv_q     <= 1'b0;
      end

      // The first beat's tree sum lands one cycle later, so loading the bias here is safe.
      if (accept && (ch_cnt_q == '0)) begin
        acc_q <= bus.in_bias;
      end else if (tv_q) begin
        acc_q <= acc_q + tree_ext;
      end

      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            state_q <= last_beat ? StDrain : StAccum;
          end
        end
        StDrain: begin
          out_q_q     <= clip;
          out_sat_q   <= sat_hi || sat_lo;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
